// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, run protocol and branch-target LUT for the 9-bit core
module pc_sequencer #(
    parameter int          PC_W      = 8,
    parameter int          LUT_DEPTH = 32,
    parameter logic [7:0]  LAST_ADDR = 8'hFE,
    parameter int          CNT_W     = 16,
    localparam int         IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    input  logic [1:0]       br_mode_i,
    input  logic [IDX_W-1:0] br_idx_i,
    input  logic             lut_we_i,
    input  logic [IDX_W-1:0] lut_waddr_i,
    input  logic [PC_W-1:0]  lut_wdata_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             running_o,
    output logic             done_o,
    output logic [CNT_W-1:0] instr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ABS = 2'b00;
    localparam logic [1:0] MODE_FWD = 2'b01;
    localparam logic [1:0] MODE_BWD = 2'b10;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  lut_q [LUT_DEPTH];

    logic [PC_W-1:0]  lut_rdata;
    logic             br_take;

    // Read of the registered array, so a same-cycle write is not seen by the branch
    assign lut_rdata = lut_q[br_idx_i];
    assign br_take   = br_valid_i && br_taken_i && (br_mode_i != 2'b11);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!stall_i) begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if (br_take) begin
                        unique case (br_mode_i)
                            MODE_ABS: pc_d = lut_rdata;
                            MODE_FWD: pc_d = pc_q + lut_rdata;
                            MODE_BWD: pc_d = pc_q - lut_rdata;
                            default:  pc_d = pc_q + PC_W'(1);
                        endcase
                    end else if (pc_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we_i) begin
            lut_q[lut_waddr_i] <= lut_wdata_i;
        end
    end

    assign pc_o          = pc_q;
    assign running_o     = (state_q == ST_RUN);
    assign done_o        = (state_q == ST_DONE);
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with LAST_ADDR=8'h04
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [1:0]  br_mode;
    logic [4:0]  br_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [7:0]  lut_wdata;
    logic [7:0]  pc;
    logic        running;
    logic        done;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    pc_sequencer #(
        .PC_W      (8),
        .LUT_DEPTH (32),
        .LAST_ADDR (8'h04),
        .CNT_W     (16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .stall_i       (stall),
        .br_valid_i    (br_valid),
        .br_taken_i    (br_taken),
        .br_mode_i     (br_mode),
        .br_idx_i      (br_idx),
        .lut_we_i      (lut_we),
        .lut_waddr_i   (lut_waddr),
        .lut_wdata_i   (lut_wdata),
        .pc_o          (pc),
        .running_o     (running),
        .done_o        (done),
        .instr_count_o (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start    = 1'b0;
        stall    = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_mode  = 2'b00;
        br_idx   = '0;
        lut_we   = 1'b0;
        lut_waddr = '0;
        lut_wdata = '0;
    endtask

    task automatic branch(input logic [1:0] mode, input logic [4:0] idx, input logic taken);
        br_valid = 1'b1;
        br_taken = taken;
        br_mode  = mode;
        br_idx   = idx;
    endtask

    task automatic lut_write(input logic [4:0] idx, input logic [7:0] data);
        lut_we    = 1'b1;
        lut_waddr = idx;
        lut_wdata = data;
    endtask

    // One retiring RUN cycle: inputs set up by the caller, then cleared
    task automatic run_step(input string tag, input logic [7:0] exp_pc);
        tick();
        exp_cnt++;
        clear_inputs();
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_cnt"}, instr_count, exp_cnt);
        check({tag, "_run"}, running, 1);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_pc", pc, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_cnt", instr_count, 0);
        reset = 1'b0;

        // IDLE ignores branches
        lut_write(5'd9, 8'h33);
        tick();
        clear_inputs();
        branch(2'b00, 5'd9, 1'b1);
        tick();
        clear_inputs();
        check("idle_pc", pc, 0);
        check("idle_running", running, 0);

        // Plain run to LAST_ADDR
        start = 1'b1;
        tick();
        clear_inputs();
        exp_cnt = 0;
        check("start_pc", pc, 0);
        check("start_running", running, 1);
        check("start_cnt", instr_count, 0);
        for (int i = 1; i <= 4; i++) begin
            start = (i == 2);
            run_step("seq", 8'(i));
        end
        tick();
        check("end_done", done, 1);
        check("end_running", running, 0);
        check("end_cnt", instr_count, 5);
        check("end_pc", pc, 8'h04);
        tick();
        check("hold_pc", pc, 8'h04);
        check("hold_cnt", instr_count, 5);
        check("hold_done", done, 1);

        // Restart from DONE
        start = 1'b1;
        tick();
        clear_inputs();
        exp_cnt = 0;
        check("restart_pc", pc, 0);
        check("restart_cnt", instr_count, 0);
        check("restart_done", done, 0);
        check("restart_running", running, 1);

        // Absolute branch taken / not taken
        lut_write(5'd3, 8'h20);        run_step("w3", 8'h01);
                                       run_step("s2", 8'h02);
        branch(2'b00, 5'd3, 1'b1);     run_step("abs_taken", 8'h20);
        lut_write(5'd0, 8'h02);        run_step("w0", 8'h21);
        branch(2'b00, 5'd0, 1'b1);     run_step("abs_back", 8'h02);
        branch(2'b00, 5'd3, 1'b0);     run_step("abs_not_taken", 8'h03);

        // Relative modes, reserved mode, branch at LAST_ADDR, wrap at 8'hFF
        lut_write(5'd1, 8'h05);        run_step("w1", 8'h04);
        branch(2'b00, 5'd3, 1'b1);     run_step("last_branch", 8'h20);
        lut_write(5'd4, 8'h10);        run_step("w4", 8'h21);
        branch(2'b00, 5'd4, 1'b1);     run_step("to10", 8'h10);
        branch(2'b01, 5'd1, 1'b1);     run_step("fwd", 8'h15);
        lut_write(5'd5, 8'h03);        run_step("w5", 8'h16);
        branch(2'b00, 5'd5, 1'b1);     run_step("to03", 8'h03);
        branch(2'b10, 5'd1, 1'b1);     run_step("bwd_wrap", 8'hFE);
        branch(2'b11, 5'd1, 1'b1);     run_step("mode11", 8'hFF);
                                       run_step("ff_wrap", 8'h00);

        // Stall with a pending taken branch
        lut_write(5'd6, 8'h07);        run_step("w6", 8'h01);
        branch(2'b00, 5'd6, 1'b1);     run_step("to07", 8'h07);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            branch(2'b00, 5'd3, 1'b1);
            tick();
            check("stall_pc", pc, 8'h07);
            check("stall_cnt", instr_count, exp_cnt);
        end
        stall = 1'b0;
        branch(2'b00, 5'd3, 1'b1);     run_step("stall_release", 8'h20);

        // Write and branch to the same index in one cycle
        lut_write(5'd2, 8'h08);        run_step("w2", 8'h21);
        lut_write(5'd2, 8'h30);
        branch(2'b00, 5'd2, 1'b1);     run_step("wr_bypass_old", 8'h08);
        branch(2'b00, 5'd2, 1'b1);     run_step("wr_new", 8'h30);

        // Reset mid-run clears state and LUT
        lut_write(5'd7, 8'h40);        run_step("w7", 8'h31);
        branch(2'b00, 5'd7, 1'b1);     run_step("to40", 8'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cnt", instr_count, 0);
        start = 1'b1;
        tick();
        clear_inputs();
        exp_cnt = 0;
        branch(2'b00, 5'd3, 1'b1);     run_step("lut_cleared", 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch sequencer for the 9-bit, 4-register core, sitting directly upstream of instruction memory.
- Owns the start/done run protocol and the 8-bit PC.
- Resolves taken branches through a 32-entry programmable branch-target LUT in three modes: absolute (BEQ/BLT/BLTE/BUN), forward-relative (BF) and backward-relative (BB).
- Counts retired instructions for the harness.

Parameters:
PC_W, 8, PC and LUT entry width.
LUT_DEPTH, 32, number of branch-target entries; index width is 5.
LAST_ADDR, 8'hFE, address of the final program instruction; retiring it without a taken branch ends the run.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  level or pulse; launches a run from IDLE or DONE.
stall  in  1  hold PC this cycle; no retire.
br_valid  in  1  the current instruction is a branch.
br_taken  in  1  branch condition is met (from control/ALU flags).
br_mode  in  2  00 absolute, 01 forward (pc+off), 10 backward (pc-off), 11 reserved.
br_idx  in  5  LUT index from the instruction immediate.
lut_we  in  1  LUT write enable.
lut_waddr  in  5  LUT write index.
lut_wdata  in  8  LUT write data.
pc  out  8  current fetch address to instruction memory.
running  out  1  high in RUN.
done  out  1  high in DONE.
instr_count  out  16  instructions retired in the current run, saturating.

Behaviour:
- Reset: state=IDLE, pc=0, running=0, done=0, instr_count=0, all LUT entries=0. Reset mid-run aborts immediately; no partial retire.
- States: IDLE, RUN, DONE. Outputs are registered; running and done decode the state register.
- IDLE:
  - pc is held at 0.
  - start=1 moves to RUN next cycle with pc=0 and instr_count=0.
  - Branch inputs are ignored.
- RUN, per cycle:
  - stall=1: pc, instr_count and state hold. Stall has priority over everything else.
  - Otherwise one instruction retires and instr_count increments, saturating at 16'hFFFF.
  - br_valid & br_taken & mode 00: pc <= LUT[br_idx].
  - mode 01: pc <= pc + LUT[br_idx], modulo 256.
  - mode 10: pc <= pc - LUT[br_idx], modulo 256.
  - mode 11, or not taken, or br_valid=0: pc <= pc + 1.
  - pc == LAST_ADDR and no taken branch: go to DONE; pc holds at LAST_ADDR; the final instruction is counted.
  - pc == LAST_ADDR with a taken branch: the branch wins and the block stays in RUN.
  - Sequential increment at pc=8'hFF wraps to 0 and the block stays in RUN (LAST_ADDR defines the end, not the wrap).
  - start is ignored while in RUN.
- DONE:
  - done=1 is held; pc and instr_count are frozen.
  - start=1 returns to RUN next cycle with pc=0 and instr_count cleared; done drops the same cycle running rises.
- Branch latency: a branch resolved in cycle N sets the target pc at edge N+1. There are no delay slots.
- LUT:
  - Write is synchronous and allowed in any state.
  - Read is combinational from the registered array.
  - Write and branch to the same index in the same cycle: the branch uses the old value; the new value is visible next cycle.

Test Plan:
1. Reset, start pulse, no branches, LAST_ADDR=8'h04 -> pc sequence 0,1,2,3,4; done rises the cycle after pc=4 retires; instr_count=5; pc holds 4.
2. LUT[3]=8'h20; at pc=2 assert br_valid, br_taken, mode 00, idx 3 -> next pc=8'h20. Repeat with br_taken=0 -> next pc=3.
3. LUT[1]=8'h05; at pc=8'h10, mode 01 -> pc=8'h15. At pc=8'h03, mode 10 -> pc=8'hFE (wrap). Mode 11 -> pc+1.
4. Stall held 3 cycles at pc=7 with br_valid=1 and br_taken=1 -> pc stays 7 and instr_count does not advance; on release the branch is taken.
5. In the same cycle, lut_we to idx 2 (old 8'h08, new 8'h30) and a taken absolute branch to idx 2 -> pc=8'h08; a repeat branch on the next cycle -> pc=8'h30.
6. Assert reset while in RUN at pc=8'h40 -> next cycle IDLE, pc=0, count=0, LUT cleared. Start in DONE -> restarts at pc=0 with count=0.
